// File: rtl/fp_cast_dispatcher_pkg.sv
// Shared types and widths for the APU cast dispatcher: request/response structs and a saturating counter helper.
package fp_cast_dispatcher_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int NDSFLAGS_CAST = 3;
  localparam int NUSFLAGS_CAST = 5;
  localparam int TAG_WIDTH     = 4;
  localparam int RND_WIDTH     = NDSFLAGS_CAST;
  localparam int STAT_WIDTH    = NUSFLAGS_CAST;

  typedef struct packed {
    logic                  f2i;
    logic [FP_WIDTH-1:0]   opa;
    logic [RND_WIDTH-1:0]  rnd;
    logic [TAG_WIDTH-1:0]  tag;
  } cast_req_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0]   res;
    logic [STAT_WIDTH-1:0] status;
    logic [TAG_WIDTH-1:0]  tag;
  } cast_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fp_cast_resp_fifo.sv
// Circular-buffer FIFO with occupancy count; head is visible combinationally, zero added latency.
// Push while full is dropped unless a pop happens in the same cycle.
module fp_cast_resp_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the simultaneous push lands in, so full+pop+push is legal.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/fp_cast_dispatcher.sv
// Cast-unit initiator: 1-cycle request-to-issue, credit-gated so the non-stallable cast unit never overruns the response FIFO.
// Optional perf counters are built when FP_CAST_DISP_PERF_CNT_EN is defined.
module fp_cast_dispatcher
  import fp_cast_dispatcher_pkg::*;
#(
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_f2i_i,
  input  logic [FP_WIDTH-1:0]   req_opa_i,
  input  logic [RND_WIDTH-1:0]  req_rnd_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  cast_en_o,
  output logic                  cast_f2i_o,
  output logic [FP_WIDTH-1:0]   cast_opa_o,
  output logic [RND_WIDTH-1:0]  cast_rnd_o,
  output logic [TAG_WIDTH-1:0]  cast_tag_o,
  input  logic                  cast_ready_i,
  input  logic                  cast_valid_i,
  input  logic [FP_WIDTH-1:0]   cast_res_i,
  input  logic [STAT_WIDTH-1:0] cast_status_i,
  input  logic [TAG_WIDTH-1:0]  cast_tag_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [FP_WIDTH-1:0]   resp_res_o,
  output logic [STAT_WIDTH-1:0] resp_status_o,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic                  busy_o,
  output logic                  ovf_err_o
`ifdef FP_CAST_DISP_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issue_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  cast_req_t     issue_q;
  logic          issue_vld;
  logic [CW-1:0] credits;
  logic          accept;
  logic          issue_done;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  cast_rsp_t     push_rsp;
  cast_rsp_t     head_rsp;

  assign req_ready_o = (credits != '0) && (!issue_vld || cast_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign issue_done  = issue_vld && cast_ready_i;
  assign pop         = resp_valid_o && resp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_vld <= 1'b0;
      issue_q   <= '0;
    end else if (accept) begin
      issue_vld <= 1'b1;
      issue_q   <= cast_req_t'{f2i: req_f2i_i, opa: req_opa_i, rnd: req_rnd_i, tag: req_tag_i};
    end else if (issue_done) begin
      issue_vld <= 1'b0;
    end
  end

  // Each credit reserves one FIFO slot from accept until the requester pops the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits <= CW'(RESP_DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !accept && (credits != CW'(RESP_DEPTH))) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_err_o <= 1'b0;
    else if (cast_valid_i && fifo_full && !pop) ovf_err_o <= 1'b1;
  end

  assign cast_en_o  = issue_vld;
  assign cast_f2i_o = issue_q.f2i;
  assign cast_opa_o = issue_vld ? issue_q.opa : '0;
  assign cast_rnd_o = issue_q.rnd;
  assign cast_tag_o = issue_q.tag;

  assign push_rsp = cast_rsp_t'{res: cast_res_i, status: cast_status_i, tag: cast_tag_i};

  fp_cast_resp_fifo #(
    .WIDTH ($bits(cast_rsp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (cast_valid_i),
    .push_data (push_rsp),
    .pop       (pop),
    .head      (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Storage is not reset, so the head is masked until something valid is there.
  assign resp_valid_o  = (fifo_count != '0);
  assign resp_res_o    = fifo_empty ? '0 : head_rsp.res;
  assign resp_status_o = fifo_empty ? '0 : head_rsp.status;
  assign resp_tag_o    = fifo_empty ? '0 : head_rsp.tag;

  assign busy_o = issue_vld || (credits != CW'(RESP_DEPTH));

`ifdef FP_CAST_DISP_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issue_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (issue_done)                  perf_issue_cnt_o <= sat_inc(perf_issue_cnt_o);
      if (req_valid_i && !req_ready_o) perf_stall_cnt_o <= sat_inc(perf_stall_cnt_o);
    end
  end
`endif

endmodule
